// File: rtl/fetch_queue_if.sv
// Fetch-queue handshake bundle: PC register, I-cache request/response and decode channels.
// The master modport is the queue itself; the slave modport is its surroundings.
interface fetch_queue_if #(
  parameter int PC_W = 32
);
  logic [PC_W-1:0] pc;
  logic            pc_we;
  logic            req_valid;
  logic [PC_W-1:0] req_addr;
  logic            req_ready;
  logic            resp_valid;
  logic [PC_W-1:0] resp_data;
  logic            flush;
  logic            out_valid;
  logic [PC_W-1:0] out_pc;
  logic [PC_W-1:0] out_inst;
  logic            out_ready;

  modport master (
    input  pc, req_ready, resp_valid, resp_data, flush, out_ready,
    output pc_we, req_valid, req_addr, out_valid, out_pc, out_inst
  );

  modport slave (
    output pc, req_ready, resp_valid, resp_data, flush, out_ready,
    input  pc_we, req_valid, req_addr, out_valid, out_pc, out_inst
  );
endinterface

// File: rtl/fetch_queue.sv
// Circular fetch queue between the PC register, an in-order I-cache and decode.
// Define FETCH_PERF_EN to add the 32-bit saturating perf_stall_cnt output.
module fetch_queue #(
  parameter int DEPTH = 4,
  parameter int PC_W  = 32
) (
  input  logic          clk,
  input  logic          rst,
  fetch_queue_if.master bus
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]   perf_stall_cnt
`endif
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  // Outstanding responses can exceed DEPTH across back-to-back redirects.
  localparam int DW = CW + 1;

  logic [PW-1:0]   head_reg, head_next, tail_reg, tail_next, fill_idx;
  logic [CW-1:0]   count_reg, count_next, pending_reg, pending_next;
  logic [DW-1:0]   drop_cnt_reg, drop_cnt_next, outstanding;
  logic [DEPTH-1:0] filled_reg, filled_next;
  logic [PC_W-1:0] slot_pc_reg   [DEPTH];
  logic [PC_W-1:0] slot_pc_next  [DEPTH];
  logic [PC_W-1:0] slot_inst_reg [DEPTH];
  logic [PC_W-1:0] slot_inst_next[DEPTH];
  logic            out_valid_reg, out_valid_next;
  logic [PC_W-1:0] out_pc_reg, out_pc_next, out_inst_reg, out_inst_next;
  logic            req_valid, alloc, fill, drop, deliver;

  assign req_valid   = !rst && !bus.flush && (count_reg < CW'(DEPTH));
  assign alloc       = req_valid && bus.req_ready;
  assign deliver     = out_valid_reg && bus.out_ready && !bus.flush;
  assign drop        = bus.resp_valid && (drop_cnt_reg != '0);
  assign fill        = bus.resp_valid && (drop_cnt_reg == '0) && (pending_reg != '0) && !bus.flush;
  // pending counts allocated-but-unfilled slots, which always sit just behind the tail
  assign fill_idx    = tail_reg - PW'(pending_reg);
  assign outstanding = drop_cnt_reg + DW'(pending_reg);

  always_comb begin
    head_next      = head_reg;
    tail_next      = tail_reg;
    count_next     = count_reg;
    pending_next   = pending_reg;
    drop_cnt_next  = drop_cnt_reg;
    filled_next    = filled_reg;
    slot_pc_next   = slot_pc_reg;
    slot_inst_next = slot_inst_reg;
    if (bus.flush) begin
      head_next    = '0;
      tail_next    = '0;
      count_next   = '0;
      pending_next = '0;
      filled_next  = '0;
      // A response landing in the flush cycle is one of the outstanding ones; it is consumed now.
      if (bus.resp_valid && (outstanding != '0))
        drop_cnt_next = outstanding - 1'b1;
      else
        drop_cnt_next = outstanding;
    end else begin
      if (alloc) begin
        slot_pc_next[tail_reg] = bus.pc;
        filled_next[tail_reg]  = 1'b0;
        tail_next              = tail_reg + 1'b1;
      end
      if (fill) begin
        slot_inst_next[fill_idx] = bus.resp_data;
        filled_next[fill_idx]    = 1'b1;
      end
      if (drop)
        drop_cnt_next = drop_cnt_reg - 1'b1;
      if (deliver) begin
        filled_next[head_reg] = 1'b0;
        head_next             = head_reg + 1'b1;
      end
      count_next   = count_reg + CW'(alloc) - CW'(deliver);
      pending_next = pending_reg + CW'(alloc) - CW'(fill);
    end
    out_valid_next = (count_next != '0) && filled_next[head_next];
    out_pc_next    = out_valid_next ? slot_pc_next[head_next]   : '0;
    out_inst_next  = out_valid_next ? slot_inst_next[head_next] : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_reg      <= '0;
      tail_reg      <= '0;
      count_reg     <= '0;
      pending_reg   <= '0;
      drop_cnt_reg  <= '0;
      filled_reg    <= '0;
      out_valid_reg <= 1'b0;
      out_pc_reg    <= '0;
      out_inst_reg  <= '0;
    end else begin
      head_reg      <= head_next;
      tail_reg      <= tail_next;
      count_reg     <= count_next;
      pending_reg   <= pending_next;
      drop_cnt_reg  <= drop_cnt_next;
      filled_reg    <= filled_next;
      out_valid_reg <= out_valid_next;
      out_pc_reg    <= out_pc_next;
      out_inst_reg  <= out_inst_next;
    end
  end

  // Slot payloads need no reset: the filled flags and out_valid gate every read.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
      always_ff @(posedge clk) begin
        slot_pc_reg[gi]   <= slot_pc_next[gi];
        slot_inst_reg[gi] <= slot_inst_next[gi];
      end
    end
  endgenerate

  assign bus.req_valid = req_valid;
  assign bus.req_addr  = bus.pc;
  assign bus.pc_we     = alloc;
  assign bus.out_valid = out_valid_reg;
  assign bus.out_pc    = out_pc_reg;
  assign bus.out_inst  = out_inst_reg;

`ifdef FETCH_PERF_EN
  logic [31:0] perf_stall_cnt_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      perf_stall_cnt_reg <= '0;
    else if (req_valid && !bus.req_ready && (perf_stall_cnt_reg != '1))
      perf_stall_cnt_reg <= perf_stall_cnt_reg + 1'b1;
  end

  assign perf_stall_cnt = perf_stall_cnt_reg;
`endif
endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of fetch slots (power of two, 2..16).
REQ-002 SHALL have parameter PC_W, default 32, program-counter and instruction width.
REQ-003 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port pc  input  PC_W  current value held by the PC register.
REQ-006 SHALL have port pc_we  output  1  PC register write enable; PC advances when high.
REQ-007 SHALL have ports req_valid output 1, req_addr output PC_W, req_ready input 1: I-cache fetch request channel.
REQ-008 SHALL have ports resp_valid input 1, resp_data input PC_W: I-cache response, in order, one per accepted request, no backpressure.
REQ-009 SHALL have port flush  input  1  redirect; discard all queued and in-flight fetches.
REQ-010 SHALL have ports out_valid output 1, out_pc output PC_W, out_inst output PC_W, out_ready input 1: decode-side channel.

Function
REQ-011 SHALL hold DEPTH slots in a circular buffer; each slot holds pc, instruction, and a filled flag.
REQ-012 SHALL allocate the tail slot with pc when req_valid && req_ready; slot filled flag cleared.
REQ-013 SHALL drive req_valid = !rst && !flush && (allocated slots < DEPTH); req_addr = pc, combinationally.
REQ-014 SHALL drive pc_we = req_valid && req_ready; exactly one PC advance per accepted request.
REQ-015 SHALL write resp_data into the oldest allocated unfilled slot and set its filled flag when resp_valid and drop_cnt == 0.
REQ-016 SHALL drive out_valid = head slot allocated and filled; out_pc/out_inst from head slot, registered, zero when out_valid low.
REQ-017 SHALL free the head slot when out_valid && out_ready; allocate and free in the same cycle SHALL leave the count unchanged.
REQ-018 SHALL, at full (DEPTH allocated), hold req_valid and pc_we low until a slot frees; no overflow.
REQ-019 SHALL, on flush, deallocate all slots next cycle, set drop_cnt to the number of allocated unfilled slots, and deassert out_valid.
REQ-020 SHALL decrement drop_cnt and discard resp_data for each resp_valid while drop_cnt > 0.
REQ-021 SHALL treat a response arriving in the flush cycle as discarded and exclude it from the new drop_cnt.
REQ-022 SHALL ignore out_ready in the flush cycle; no slot is delivered.
REQ-023 SHALL wrap head and tail pointers modulo DEPTH; count SHALL be log2(DEPTH)+1 bits.

Reset
REQ-024 SHALL clear head, tail, count, drop_cnt and all filled flags immediately on rst high.
REQ-025 SHALL hold req_valid, pc_we, out_valid low and out_pc, out_inst at 0 while rst is high.
REQ-026 SHALL accept the first request on the first rising edge after rst deasserts if req_ready is high.

Configuration
REQ-027 SHALL, when FETCH_PERF_EN is defined, add output perf_stall_cnt (32 bits), counting cycles with req_valid high and req_ready low, saturating at all-ones, cleared by rst.
REQ-028 SHALL, when FETCH_PERF_EN is undefined, omit perf_stall_cnt and all its logic; other behaviour identical.

Verification
REQ-029 SHALL cover streaming: req_ready=1, 1-cycle response latency, out_ready=1, pc 0,4,8 -> out_pc 0,4,8 in order, pc_we high every cycle.
REQ-030 SHALL cover full: out_ready=0, DEPTH=4, 4 requests accepted -> req_valid=0, pc_we=0 until one out_ready pulse, then exactly one new request.
REQ-031 SHALL cover flush with 2 in-flight requests -> drop_cnt=2, next 2 responses discarded, third response delivered with the new pc.
REQ-032 SHALL cover simultaneous flush and resp_valid with 3 unfilled slots -> drop_cnt=2, out_valid stays 0 until a post-flush fetch returns.
REQ-033 SHALL cover async reset mid-stream with 3 slots filled -> out_valid, req_valid, pc_we low same cycle; count=0 after release.
REQ-034 SHALL cover FETCH_PERF_EN: req_ready low for 5 cycles with req_valid high -> perf_stall_cnt=5.
